// File: rtl/ab_frame_sync.sv
// Frame synchroniser and byte assembler for absolute-code dibits: hunts for SYNC_WORD,
// packs payload into bytes, and flywheels over up to LOSS_CNT-1 consecutive sync misses.
module ab_frame_sync #(
  parameter logic [15:0] SYNC_WORD   = 16'hEB90,
  parameter int          MAX_ERR     = 1,
  parameter int          FRAME_BYTES = 8,
  parameter int          LOSS_CNT    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ab,
  input  logic       ab_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       sof,
  output logic       locked,
  output logic       sync_miss
);

  typedef enum logic [1:0] {HUNT, PAYLOAD, VERIFY} state_t;

  localparam logic [4:0] ERR_LIM   = 5'(MAX_ERR);
  localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);
  localparam logic [2:0] LOSS_LIM  = 3'(LOSS_CNT);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_sr, w_sr_nxt, w_sr_shift;
  logic [5:0]  r_bsr, w_bsr_nxt;
  logic [2:0]  r_dcnt, w_dcnt_nxt;
  logic [7:0]  r_bcnt, w_bcnt_nxt;
  logic [2:0]  r_miss, w_miss_nxt, w_miss_inc;
  logic [7:0]  r_bout, w_bout_nxt;
  logic        r_bv, w_bv_nxt;
  logic        r_sof, w_sof_nxt;
  logic        r_smiss, w_smiss_nxt;
  logic        r_locked, w_locked_nxt;
  logic [4:0]  w_dist;
  logic        w_match;

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  // Match is judged on the window that already includes this cycle's dibit.
  assign w_sr_shift = {r_sr[13:0], ab};
  assign w_dist     = popcnt16(w_sr_shift ^ SYNC_WORD);
  assign w_match    = (w_dist <= ERR_LIM);
  assign w_miss_inc = r_miss + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= HUNT;
      r_sr     <= '0;
      r_bsr    <= '0;
      r_dcnt   <= '0;
      r_bcnt   <= '0;
      r_miss   <= '0;
      r_bout   <= '0;
      r_bv     <= 1'b0;
      r_sof    <= 1'b0;
      r_smiss  <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sr     <= w_sr_nxt;
      r_bsr    <= w_bsr_nxt;
      r_dcnt   <= w_dcnt_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_miss   <= w_miss_nxt;
      r_bout   <= w_bout_nxt;
      r_bv     <= w_bv_nxt;
      r_sof    <= w_sof_nxt;
      r_smiss  <= w_smiss_nxt;
      r_locked <= w_locked_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_bsr_nxt   = r_bsr;
    w_dcnt_nxt  = r_dcnt;
    w_bcnt_nxt  = r_bcnt;
    w_miss_nxt  = r_miss;
    w_bout_nxt  = r_bout;
    w_bv_nxt    = 1'b0;
    w_sof_nxt   = 1'b0;
    w_smiss_nxt = 1'b0;
    if (ab_valid) begin
      w_sr_nxt = w_sr_shift;
      case (r_state)
        HUNT: begin
          if (w_match) begin
            w_state_nxt = PAYLOAD;
            w_dcnt_nxt  = '0;
            w_bcnt_nxt  = '0;
            w_miss_nxt  = '0;
          end
        end
        PAYLOAD: begin
          w_bsr_nxt  = {r_bsr[3:0], ab};
          w_dcnt_nxt = {1'b0, r_dcnt[1:0] + 2'd1};
          if (r_dcnt[1:0] == 2'd3) begin
            w_bout_nxt = {r_bsr, ab};
            w_bv_nxt   = 1'b1;
            w_sof_nxt  = (r_bcnt == 8'd0);
            w_bcnt_nxt = r_bcnt + 8'd1;
            if (r_bcnt == LAST_BYTE) begin
              w_state_nxt = VERIFY;
              w_dcnt_nxt  = '0;
            end
          end
        end
        VERIFY: begin
          w_dcnt_nxt = r_dcnt + 3'd1;
          if (r_dcnt == 3'd7) begin
            w_dcnt_nxt  = '0;
            w_bcnt_nxt  = '0;
            w_state_nxt = PAYLOAD;
            if (w_match) begin
              w_miss_nxt = '0;
            end else begin
              // Flywheel: keep framing unless this miss reaches the loss limit.
              w_smiss_nxt = 1'b1;
              w_miss_nxt  = w_miss_inc;
              if (w_miss_inc == LOSS_LIM) w_state_nxt = HUNT;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
    w_locked_nxt = (w_state_nxt != HUNT);
  end

  assign byte_out   = r_bout;
  assign byte_valid = r_bv;
  assign sof        = r_sof;
  assign sync_miss  = r_smiss;
  assign locked     = r_locked;

endmodule

// File: tb/tb_ab_frame_sync.sv
// Bench for ab_frame_sync: frame-position reference model checked every cycle,
// plus directed scenarios with literal expectations and a randomized soak.
module tb_ab_frame_sync;
  localparam logic [15:0] SW   = 16'hEB90;
  localparam int          MAXE = 1;
  localparam int          FB   = 8;
  localparam int          LOSS = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] ab = 2'b00;
  logic       ab_valid = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid, sof, locked, sync_miss;

  ab_frame_sync #(.SYNC_WORD(SW), .MAX_ERR(MAXE), .FRAME_BYTES(FB), .LOSS_CNT(LOSS)) dut (
    .clk(clk), .rst_n(rst_n), .ab(ab), .ab_valid(ab_valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .sof(sof),
    .locked(locked), .sync_miss(sync_miss)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  bit chk_en = 0;

  // Reference model: lock flag, dibit position within frame, running history bits.
  int m_lk, m_pos, m_miss, m_hist, m_acc;
  logic [7:0] e_byte;
  bit e_bv, e_sof, e_smiss, e_lk;

  logic [7:0] got[$];
  bit         sofq[$];
  int         n_smiss_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_lk = 0; m_pos = 0; m_miss = 0; m_hist = 0; m_acc = 0;
    e_byte = 8'h00; e_bv = 0; e_sof = 0; e_smiss = 0; e_lk = 0;
  endfunction

  function automatic void model_dibit(input logic [1:0] d);
    bit match;
    e_bv = 0; e_sof = 0; e_smiss = 0;
    m_hist = ((m_hist << 2) | int'(d)) & 32'hFFFF;
    match  = ($countones(16'(m_hist) ^ SW) <= MAXE);
    if (m_lk == 0) begin
      if (match) begin m_lk = 1; m_pos = 0; m_miss = 0; end
    end else if (m_pos < 4*FB) begin
      m_acc = ((m_acc << 2) | int'(d)) & 255;
      m_pos++;
      if (m_pos % 4 == 0) begin
        e_bv = 1; e_byte = 8'(m_acc); e_sof = (m_pos == 4);
      end
    end else begin
      m_pos++;
      if (m_pos == 4*FB + 8) begin
        m_pos = 0;
        if (match) m_miss = 0;
        else begin
          e_smiss = 1; m_miss++;
          if (m_miss == LOSS) m_lk = 0;
        end
      end
    end
    e_lk = (m_lk != 0);
  endfunction

  // Per-cycle compare against the model, plus capture of delivered bytes.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("byte_valid", 32'(byte_valid), 32'(e_bv));
      chk("sof",        32'(sof),        32'(e_sof));
      chk("sync_miss",  32'(sync_miss),  32'(e_smiss));
      chk("locked",     32'(locked),     32'(e_lk));
      chk("byte_out",   32'(byte_out),   32'(e_byte));
    end
    if (byte_valid === 1'b1) begin got.push_back(byte_out); sofq.push_back(sof); end
    if (sync_miss === 1'b1) n_smiss_seen++;
  end

  task automatic step(input bit v, input logic [1:0] d);
    ab_valid = v;
    ab = v ? d : 2'($urandom);
    if (v) model_dibit(d);
    else begin e_bv = 0; e_sof = 0; e_smiss = 0; end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_dibit(input logic [1:0] d, input int gap);
    int n;
    n = (gap < 0) ? int'($urandom_range(0, 6)) : gap;
    for (int i = 0; i < n; i++) step(0, 2'b00);
    step(1, d);
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    for (int i = 7; i >= 0; i--) send_dibit(w[2*i +: 2], gap);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 3; i >= 0; i--) send_dibit(b[2*i +: 2], gap);
  endtask

  task automatic send_frame(input logic [15:0] s, input int gap);
    send_word(s, gap);
    for (int i = 1; i <= FB; i++) send_byte(8'(i), gap);
  endtask

  // Reset lands mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    ab_valid = 0;
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_locked",     32'(locked),     32'd0);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_out",   32'(byte_out),   32'd0);
    chk("rst_sof",        32'(sof),        32'd0);
    chk("rst_sync_miss",  32'(sync_miss),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    step(0, 2'b00);
    got.delete(); sofq.delete();
  endtask

  task automatic check_bytes(input string nm);
    int nsof;
    nsof = 0;
    chk({nm, "_nbytes"}, 32'(got.size()), 32'(FB));
    for (int i = 0; i < got.size() && i < FB; i++) begin
      chk({nm, "_byte"}, 32'(got[i]), 32'(i + 1));
      if (sofq[i]) nsof++;
    end
    if (sofq.size() > 0) chk({nm, "_sof_first"}, 32'(sofq[0]), 32'd1);
    chk({nm, "_sof_count"}, 32'(nsof), 32'd1);
    got.delete(); sofq.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk_en = 1;

    // 1: clean frame, back-to-back dibits
    send_frame(SW, 0);
    chk("t1_locked", 32'(locked), 32'd1);
    check_bytes("t1");

    // 2: one-bit error still locks, two-bit error does not
    do_reset();
    send_frame(16'hEB91, 0);
    chk("t2_locked_1err", 32'(locked), 32'd1);
    check_bytes("t2");
    do_reset();
    send_word(16'hEB93, 0);
    chk("t2_locked_2err", 32'(locked), 32'd0);
    for (int i = 1; i <= FB; i++) send_byte(8'(i), 0);

    // 3: two misses flywheel, third drops lock
    do_reset();
    send_frame(SW, 0);
    m0 = n_smiss_seen;
    send_frame(16'h0000, 0);
    send_frame(16'h0000, 0);
    chk("t3_miss2", 32'(n_smiss_seen - m0), 32'd2);
    chk("t3_locked_flywheel", 32'(locked), 32'd1);
    chk("t3_payload_bytes", 32'(got.size()), 32'(3*FB));
    send_word(16'h0000, 0);
    chk("t3_miss3", 32'(n_smiss_seen - m0), 32'd3);
    chk("t3_locked_lost", 32'(locked), 32'd0);

    // 4: a good sync clears the miss count
    do_reset();
    send_frame(SW, 0);
    m0 = n_smiss_seen;
    send_frame(16'h0000, 0);
    send_frame(SW, 0);
    send_frame(16'h0000, 0);
    send_frame(16'h0000, 0);
    chk("t4_misses", 32'(n_smiss_seen - m0), 32'd3);
    chk("t4_locked", 32'(locked), 32'd1);

    // 5: sparse and irregular ab_valid
    do_reset();
    send_frame(SW, 6);
    check_bytes("t5_every7");
    do_reset();
    send_frame(SW, -1);
    check_bytes("t5_random");

    // 6: reset mid-byte, then only a full sync word relocks
    do_reset();
    send_word(SW, 0);
    send_byte(8'h01, 0);
    send_dibit(2'b00, 0);
    send_dibit(2'b00, 0);
    chk("t6_pre_locked", 32'(locked), 32'd1);
    chk("t6_pre_byte", 32'(byte_out), 32'h01);
    do_reset();
    send_byte(8'h90, 0);
    chk("t6_partial_nolock", 32'(locked), 32'd0);
    got.delete(); sofq.delete();
    send_frame(SW, 0);
    chk("t6_relocked", 32'(locked), 32'd1);
    check_bytes("t6");

    // Randomized soak: sync quality, payload, gaps, junk and resets all random.
    for (int f = 0; f < 40; f++) begin
      int sel, gap, junk;
      logic [15:0] s;
      sel = int'($urandom_range(0, 9));
      gap = ($urandom_range(0, 1) == 0) ? 0 : -1;
      if (sel < 5)       s = SW;
      else if (sel < 7)  s = SW ^ (16'h1 << $urandom_range(0, 15));
      else               s = 16'($urandom);
      if ($urandom_range(0, 14) == 0) do_reset();
      junk = int'($urandom_range(0, 3));
      for (int j = 0; j < junk; j++) send_dibit(2'($urandom), gap);
      send_word(s, gap);
      for (int b = 0; b < FB; b++) send_byte(8'($urandom), gap);
    end

    step(0, 2'b00);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
